// File: rtl/baccarat_round_ctrl.sv
// Baccarat round controller: deals four cards, applies the third-card tableau,
// scores the hand, keeps saturating outcome tallies and ends the game after NUM_HANDS.
module baccarat_round_ctrl #(
   parameter int AUTO_DEAL   = 1,
   parameter int HOLD_CYCLES = 4,
   parameter int NUM_HANDS   = 0,
   parameter int CNT_W       = 8
) (
   input  logic             slow_clock,
   input  logic             resetb,
   input  logic             deal_req,
   input  logic [3:0]       dscore,
   input  logic [3:0]       pscore,
   input  logic [3:0]       pcard3,
   output logic             load_pcard1,
   output logic             load_pcard2,
   output logic             load_pcard3,
   output logic             load_dcard1,
   output logic             load_dcard2,
   output logic             load_dcard3,
   output logic             player_win_light,
   output logic             dealer_win_light,
   output logic             tie_light,
   output logic             hand_done,
   output logic             game_over,
   output logic             score_err,
   output logic [CNT_W-1:0] player_wins,
   output logic [CNT_W-1:0] dealer_wins,
   output logic [CNT_W-1:0] ties
);

   localparam int HT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
   localparam int HC_W = (NUM_HANDS < 2) ? 1 : $clog2(NUM_HANDS + 1);
   localparam logic [HT_W-1:0] HOLD_LOAD = HT_W'(HOLD_CYCLES);
   localparam logic [HT_W-1:0] TIMER_ONE = HT_W'(1);
   localparam logic [HC_W-1:0] HAND_LAST = HC_W'(NUM_HANDS);

   typedef enum logic [3:0] {
      S_IDLE, S_P1, S_D1, S_P2, S_D2, S_EVAL_P, S_P3, S_EVAL_D, S_D3, S_RESULT, S_HOLD, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             pwl_q, pwl_d, dwl_q, dwl_d, tie_q, tie_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] pw_q, pw_d, dw_q, dw_d, ti_q, ti_d;
   logic [HT_W-1:0]  timer_q, timer_d;
   logic [HC_W-1:0]  hand_q, hand_d;

   // Out-of-range scores read as 9, an out-of-range third card as a face card.
   logic [3:0] ps, ds, pc3;
   logic       score_bad;
   assign ps        = (pscore > 4'd9) ? 4'd9 : pscore;
   assign ds        = (dscore > 4'd9) ? 4'd9 : dscore;
   assign pc3       = (pcard3 > 4'd9) ? 4'd0 : pcard3;
   assign score_bad = (pscore > 4'd9) || (dscore > 4'd9);

   function automatic logic banker_draws(input logic [3:0] d, input logic [3:0] c);
      logic r;
      r = 1'b0;
      case (d)
         4'd0, 4'd1, 4'd2: r = 1'b1;
         4'd3:             r = (c != 4'd8);
         4'd4:             r = (c >= 4'd2) && (c <= 4'd7);
         4'd5:             r = (c >= 4'd4) && (c <= 4'd7);
         4'd6:             r = (c == 4'd6) || (c == 4'd7);
         default:          r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d = state_q;
      pwl_d   = pwl_q;
      dwl_d   = dwl_q;
      tie_d   = tie_q;
      err_d   = err_q;
      pw_d    = pw_q;
      dw_d    = dw_q;
      ti_d    = ti_q;
      timer_d = timer_q;
      hand_d  = hand_q;
      case (state_q)
         S_IDLE: if (AUTO_DEAL != 0 || deal_req) state_d = S_P1;
         S_P1:   state_d = S_D1;
         S_D1:   state_d = S_P2;
         S_P2:   state_d = S_D2;
         S_D2:   state_d = S_EVAL_P;
         S_EVAL_P: begin
            err_d = err_q | score_bad;
            if (ps >= 4'd8 || ds >= 4'd8) state_d = S_RESULT;
            else if (ps <= 4'd5)          state_d = S_P3;
            else if (ds <= 4'd5)          state_d = S_D3;
            else                          state_d = S_RESULT;
         end
         S_P3:   state_d = S_EVAL_D;
         S_EVAL_D: begin
            err_d   = err_q | score_bad;
            state_d = banker_draws(ds, pc3) ? S_D3 : S_RESULT;
         end
         S_D3:   state_d = S_RESULT;
         S_RESULT: begin
            err_d  = err_q | score_bad;
            pwl_d  = (ps >= ds);
            dwl_d  = (ds >= ps);
            tie_d  = (ps == ds);
            if (ps > ds)      pw_d = sat_inc(pw_q);
            else if (ds > ps) dw_d = sat_inc(dw_q);
            else              ti_d = sat_inc(ti_q);
            hand_d = hand_q + HC_W'(1);
            if (NUM_HANDS != 0 && hand_d == HAND_LAST) begin
               state_d = S_DONE;
            end else begin
               state_d = S_HOLD;
               timer_d = HOLD_LOAD;
            end
         end
         S_HOLD: begin
            if (timer_q <= TIMER_ONE) begin
               state_d = S_IDLE;
               pwl_d   = 1'b0;
               dwl_d   = 1'b0;
               tie_d   = 1'b0;
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge slow_clock) begin
      if (resetb) begin
         state_q <= S_IDLE;
         pwl_q   <= 1'b0;
         dwl_q   <= 1'b0;
         tie_q   <= 1'b0;
         err_q   <= 1'b0;
         pw_q    <= '0;
         dw_q    <= '0;
         ti_q    <= '0;
         timer_q <= '0;
         hand_q  <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state_q <= state_d;
         pwl_q   <= pwl_d;
         dwl_q   <= dwl_d;
         tie_q   <= tie_d;
         err_q   <= err_d;
         pw_q    <= pw_d;
         dw_q    <= dw_d;
         ti_q    <= ti_d;
         timer_q <= timer_d;
         hand_q  <= hand_d;
      end
   end

   assign load_pcard1      = (state_q == S_P1);
   assign load_dcard1      = (state_q == S_D1);
   assign load_pcard2      = (state_q == S_P2);
   assign load_dcard2      = (state_q == S_D2);
   assign load_pcard3      = (state_q == S_P3);
   assign load_dcard3      = (state_q == S_D3);
   assign hand_done        = (state_q == S_RESULT);
   assign game_over        = (state_q == S_DONE);
   assign player_win_light = pwl_q;
   assign dealer_win_light = dwl_q;
   assign tie_light        = tie_q;
   assign score_err        = err_q;
   assign player_wins      = pw_q;
   assign dealer_wins      = dw_q;
   assign ties             = ti_q;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for baccarat_round_ctrl: the bench plays the card datapath and predicts each
// hand from the rules of baccarat, across three parameter sets.
module tb_baccarat_round_ctrl;

   logic slow_clock = 1'b0;
   always #5 slow_clock = ~slow_clock;

   logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
   logic       deal_req = 1'b0;
   logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;

   // strobe bit order: 0=P1 1=D1 2=P2 3=D2 4=P3 5=D3; lights: 0=player 1=dealer 2=tie
   wire [5:0] a_ld, b_ld, c_ld;
   wire [2:0] a_li, b_li, c_li;
   wire       a_hd, b_hd, c_hd, a_go, b_go, c_go, a_se, b_se, c_se;
   wire [7:0] a_pw, a_dw, a_ti;
   wire [1:0] b_pw, b_dw, b_ti, c_pw, c_dw, c_ti;

   baccarat_round_ctrl #(.AUTO_DEAL(1), .HOLD_CYCLES(4), .NUM_HANDS(0), .CNT_W(8)) u_a (
      .slow_clock(slow_clock), .resetb(rst_a), .deal_req(deal_req),
      .dscore(dscore), .pscore(pscore), .pcard3(pcard3),
      .load_pcard1(a_ld[0]), .load_dcard1(a_ld[1]), .load_pcard2(a_ld[2]),
      .load_dcard2(a_ld[3]), .load_pcard3(a_ld[4]), .load_dcard3(a_ld[5]),
      .player_win_light(a_li[0]), .dealer_win_light(a_li[1]), .tie_light(a_li[2]),
      .hand_done(a_hd), .game_over(a_go), .score_err(a_se),
      .player_wins(a_pw), .dealer_wins(a_dw), .ties(a_ti));

   baccarat_round_ctrl #(.AUTO_DEAL(0), .HOLD_CYCLES(2), .NUM_HANDS(2), .CNT_W(2)) u_b (
      .slow_clock(slow_clock), .resetb(rst_b), .deal_req(deal_req),
      .dscore(dscore), .pscore(pscore), .pcard3(pcard3),
      .load_pcard1(b_ld[0]), .load_dcard1(b_ld[1]), .load_pcard2(b_ld[2]),
      .load_dcard2(b_ld[3]), .load_pcard3(b_ld[4]), .load_dcard3(b_ld[5]),
      .player_win_light(b_li[0]), .dealer_win_light(b_li[1]), .tie_light(b_li[2]),
      .hand_done(b_hd), .game_over(b_go), .score_err(b_se),
      .player_wins(b_pw), .dealer_wins(b_dw), .ties(b_ti));

   baccarat_round_ctrl #(.AUTO_DEAL(1), .HOLD_CYCLES(1), .NUM_HANDS(0), .CNT_W(2)) u_c (
      .slow_clock(slow_clock), .resetb(rst_c), .deal_req(deal_req),
      .dscore(dscore), .pscore(pscore), .pcard3(pcard3),
      .load_pcard1(c_ld[0]), .load_dcard1(c_ld[1]), .load_pcard2(c_ld[2]),
      .load_dcard2(c_ld[3]), .load_pcard3(c_ld[4]), .load_dcard3(c_ld[5]),
      .player_win_light(c_li[0]), .dealer_win_light(c_li[1]), .tie_light(c_li[2]),
      .hand_done(c_hd), .game_over(c_go), .score_err(c_se),
      .player_wins(c_pw), .dealer_wins(c_dw), .ties(c_ti));

   // The instance under test is selected; the others are held in reset.
   int         sel = 0;
   logic [5:0] o_ld;
   logic [2:0] o_li;
   logic       o_hd, o_go, o_se;
   logic [7:0] o_pw, o_dw, o_ti;

   always_comb begin
      o_ld = a_ld; o_li = a_li; o_hd = a_hd; o_go = a_go; o_se = a_se;
      o_pw = a_pw; o_dw = a_dw; o_ti = a_ti;
      case (sel)
         1: begin
            o_ld = b_ld; o_li = b_li; o_hd = b_hd; o_go = b_go; o_se = b_se;
            o_pw = {6'd0, b_pw}; o_dw = {6'd0, b_dw}; o_ti = {6'd0, b_ti};
         end
         2: begin
            o_ld = c_ld; o_li = c_li; o_hd = c_hd; o_go = c_go; o_se = c_se;
            o_pw = {6'd0, c_pw}; o_dw = {6'd0, c_dw}; o_ti = {6'd0, c_ti};
         end
         default: ;
      endcase
   end

   int         n_checks = 0, n_pass = 0;
   int         hold_len, num_hands, tmax, hands_played;
   bit         manual;
   logic [7:0] e_pw, e_dw, e_ti;
   bit         e_se;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic set_rst(input logic v);
      case (sel)
         1:       rst_b = v;
         2:       rst_c = v;
         default: rst_a = v;
      endcase
   endtask

   task automatic model_clear();
      e_pw = '0; e_dw = '0; e_ti = '0; e_se = 1'b0; hands_played = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ctrl"}, {o_ld, o_li, o_hd, o_go, o_se}, 0);
      check({tag, "_tally"}, {o_pw, o_dw, o_ti}, 0);
   endtask

   // Selects an instance, resets it, checks the reset state, releases reset on a negedge.
   task automatic focus(input int s, input int hold, input int nh, input int cw, input bit man);
      @(negedge slow_clock);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; deal_req = 1'b0; sel = s;
      hold_len = hold; num_hands = nh; tmax = (1 << cw) - 1; manual = man;
      model_clear();
      @(negedge slow_clock);
      @(negedge slow_clock);
      check_reset_state("reset");
      set_rst(1'b0);
   endtask

   function automatic bit bank_rule(input int d, input int c);
      if (d <= 2) return 1'b1;
      if (d == 3) return c != 8;
      if (d == 4) return c >= 2 && c <= 7;
      if (d == 5) return c >= 4 && c <= 7;
      if (d == 6) return c == 6 || c == 7;
      return 1'b0;
   endfunction

   function automatic logic [7:0] sat(input logic [7:0] v);
      return (int'(v) == tmax) ? v : v + 8'd1;
   endfunction

   // One hand: cards are baccarat values; p3 may exceed 9 (read as 0). raw_p leaves the
   // player's two-card sum unreduced; abort_p3 resets the DUT as soon as P3 is loading.
   task automatic run_hand(input int p1, input int d1, input int p2, input int d2,
                           input int p3, input int d3,
                           input bit raw_p = 1'b0, input bit abort_p3 = 1'b0);
      int         c, p, d, exp_trace, exp_lat, trace, t_p1, t_hd, pv, dv, n;
      bit         pdraw, bdraw, got_hd;
      logic [2:0] e_li;

      c = (p3 > 9) ? 0 : p3;
      p = p1 + p2;
      if (raw_p) begin
         if (p > 9) begin p = 9; e_se = 1'b1; end
      end else begin
         p = p % 10;
      end
      d = (d1 + d2) % 10;
      pdraw = 1'b0; bdraw = 1'b0;
      if (p < 8 && d < 8) begin
         if (p <= 5) begin pdraw = 1'b1; bdraw = bank_rule(d, c); end
         else        bdraw = (d <= 5);
      end
      if (pdraw) p = (p + c) % 10;
      if (bdraw) d = (d + d3) % 10;
      exp_trace = 1234;
      if (pdraw) exp_trace = exp_trace * 10 + 5;
      if (bdraw) exp_trace = exp_trace * 10 + 6;
      exp_lat = 5 + (pdraw ? 2 : 0) + (bdraw ? 1 : 0);

      pv = 0; dv = 0; trace = 0; t_p1 = -1; t_hd = -1; got_hd = 1'b0;
      pscore = '0; dscore = '0; pcard3 = '0;
      deal_req = manual;
      for (int cyc = 0; cyc < 40 && !got_hd; cyc++) begin
         @(negedge slow_clock);
         deal_req = 1'b0;
         if (o_ld != 6'd0) begin
            case (o_ld)
               6'b000001: begin trace = trace * 10 + 1; pv += p1; t_p1 = cyc; end
               6'b000010: begin trace = trace * 10 + 2; dv += d1; end
               6'b000100: begin trace = trace * 10 + 3; pv += p2; end
               6'b001000: begin trace = trace * 10 + 4; dv += d2; end
               6'b010000: begin trace = trace * 10 + 5; pv += c; pcard3 = 4'(p3); end
               6'b100000: begin trace = trace * 10 + 6; dv += d3; end
               default:   trace = trace * 10 + 9;
            endcase
            pscore = raw_p ? 4'(pv) : 4'(pv % 10);
            dscore = 4'(dv % 10);
            if (abort_p3 && o_ld[4]) begin
               set_rst(1'b1);
               model_clear();
               @(negedge slow_clock);
               check_reset_state("abort");
               set_rst(1'b0);
               return;
            end
         end
         if (o_hd) begin got_hd = 1'b1; t_hd = cyc; end
      end
      check("hand_done_seen", got_hd, 1);
      check("strobe_trace", trace, exp_trace);
      if (got_hd) check("result_latency", t_hd - t_p1, exp_lat);

      if (p > d)      begin e_li = 3'b001; e_pw = sat(e_pw); end
      else if (d > p) begin e_li = 3'b010; e_dw = sat(e_dw); end
      else            begin e_li = 3'b111; e_ti = sat(e_ti); end
      hands_played++;

      @(negedge slow_clock);
      check("hand_done_pulse", o_hd, 0);
      check("lights", o_li, e_li);
      check("player_wins", o_pw, e_pw);
      check("dealer_wins", o_dw, e_dw);
      check("ties", o_ti, e_ti);
      check("score_err", o_se, e_se);
      if (num_hands != 0 && hands_played == num_hands) begin
         check("game_over", o_go, 1);
      end else begin
         check("game_over_low", o_go, 0);
         n = 1;
         for (int k = 0; k < 20 && o_li != 3'd0; k++) begin
            @(negedge slow_clock);
            if (o_li != 3'd0) n++;
         end
         check("hold_length", n, hold_len);
      end
   endtask

   initial begin
      bit any;

      // Auto-deal, unlimited hands, 8-bit tallies.
      focus(0, 4, 0, 8, 1'b0);
      run_hand(3, 1, 5, 2, 0, 0);          // natural 8 vs 3
      run_hand(2, 2, 2, 3, 5, 4);          // 4 vs 5, both draw, 9-9 tie
      run_hand(3, 3, 4, 3, 0, 0);          // 7 vs 6, both stand
      run_hand(3, 1, 4, 2, 0, 0);          // 7 vs 3, banker alone draws
      for (int d = 0; d < 8; d++)
         for (int c = 0; c < 10; c++)
            run_hand(1, 0, 1, d, c, int'($urandom_range(0, 9)));
      for (int i = 0; i < 100; i++)
         run_hand(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 9)));
      run_hand(6, 1, 6, 2, 0, 0, 1'b1);    // pscore 12 reads as natural 9
      run_hand(2, 2, 2, 3, 5, 4, 1'b0, 1'b1);
      run_hand(3, 3, 4, 3, 0, 0);          // tallies restart from zero

      // Manual deal, two-hand game, 2-bit tallies.
      focus(1, 2, 2, 2, 1'b1);
      any = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge slow_clock);
         any |= (o_ld != 6'd0);
      end
      check("idle_without_deal_req", any, 0);
      run_hand(3, 3, 4, 3, 0, 0);
      run_hand(3, 4, 3, 4, 0, 0);          // 6 vs natural 8 ends the game
      any = 1'b0;
      for (int k = 0; k < 10; k++) begin
         deal_req = (k % 2 == 0);
         @(negedge slow_clock);
         any |= (o_ld != 6'd0) || o_hd;
      end
      deal_req = 1'b0;
      check("done_ignores_deal_req", any, 0);
      check("done_game_over", o_go, 1);
      check("done_lights", o_li, 3'b010);
      check("done_tallies", {o_pw, o_dw, o_ti}, {8'd1, 8'd1, 8'd0});

      // Saturation of a 2-bit tally.
      focus(2, 1, 0, 2, 1'b0);
      for (int i = 0; i < 5; i++) run_hand(3, 3, 4, 3, 0, 0);
      check("player_wins_saturated", o_pw, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
